// File: rtl/bsg_dff_lane_delay.sv
// Per-lane delay stack: width_p independent 1-bit shift registers, each advancing on its own
// enable, with a saturating per-lane fill counter that tells when the output holds real data.
module bsg_dff_lane_delay #(
  parameter int unsigned                width_p     = 16,
  parameter int unsigned                depth_p     = 2,
  parameter logic [width_p-1:0]         reset_val_p = '0
) (
  input  logic                                       clk_i,
  input  logic                                       reset_i,
  input  logic [width_p-1:0]                         en_i,
  input  logic [width_p-1:0]                         data_i,
  input  logic                                       clear_i,
  output logic [width_p-1:0]                         data_o,
  output logic [width_p-1:0]                         v_o,
  output logic [width_p*$clog2(depth_p+1)-1:0]       count_o
);

  localparam int unsigned cw_lp = $clog2(depth_p + 1);
  localparam logic [cw_lp-1:0] cnt_max_lp = cw_lp'(depth_p);

  if (depth_p == 0) begin : g_bad_depth
    $error("bsg_dff_lane_delay: depth_p must be at least 1");
  end

  for (genvar b = 0; b < width_p; b++) begin : g_lane
    logic [depth_p-1:0] stage_q, stage_d, stage_shift;
    logic [cw_lp-1:0]   cnt_q, cnt_d;

    // Stage 0 is the newest sample, stage depth_p-1 drives the output.
    if (depth_p == 1) begin : g_one
      assign stage_shift = data_i[b];
    end else begin : g_many
      assign stage_shift = {stage_q[depth_p-2:0], data_i[b]};
    end

    always_comb begin
      stage_d = stage_q;
      cnt_d   = cnt_q;
      if (en_i[b]) begin
        stage_d = stage_shift;
        if (cnt_q != cnt_max_lp) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // Clear wins over the increment but leaves the data path alone.
      if (clear_i) begin
        cnt_d = '0;
      end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        stage_q <= {depth_p{reset_val_p[b]}};
        cnt_q   <= '0;
      end else begin
        stage_q <= stage_d;
        cnt_q   <= cnt_d;
      end
    end

    assign data_o[b]                  = stage_q[depth_p-1];
    assign v_o[b]                     = (cnt_q == cnt_max_lp);
    assign count_o[b*cw_lp +: cw_lp]  = cnt_q;
  end

endmodule

// File: tb/tb_bsg_dff_lane_delay.sv
// Self-checking bench for bsg_dff_lane_delay: directed vector table, hand sequences for
// gapped enables / clear / async reset, and a randomized run against a sample-log model.
module tb_bsg_dff_lane_delay;

  localparam int unsigned W  = 16;
  localparam int unsigned D  = 2;
  localparam int unsigned CW = $clog2(D + 1);
  localparam logic [W-1:0] RV = 16'hA5A5;
  localparam int unsigned HMAX = 4096;

  logic            clk_i;
  logic            reset_i;
  logic [W-1:0]    en_i;
  logic [W-1:0]    data_i;
  logic            clear_i;
  logic [W-1:0]    data_o;
  logic [W-1:0]    v_o;
  logic [W*CW-1:0] count_o;

  bsg_dff_lane_delay #(
    .width_p    (W),
    .depth_p    (D),
    .reset_val_p(RV)
  ) dut (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .en_i   (en_i),
    .data_i (data_i),
    .clear_i(clear_i),
    .data_o (data_o),
    .v_o    (v_o),
    .count_o(count_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: full log of every sample each lane accepted, plus samples since
  // reset/clear. Output is simply the sample accepted D enabled edges ago.
  bit hist [W][HMAX];
  int n_en [W];
  int since [W];

  task automatic model_reset();
    for (int b = 0; b < W; b++) begin
      n_en[b]  = 0;
      since[b] = 0;
    end
  endtask

  task automatic model_edge(input logic [W-1:0] en, input logic [W-1:0] d, input logic clr);
    for (int b = 0; b < W; b++) begin
      if (en[b]) begin
        if (n_en[b] < HMAX) hist[b][n_en[b]] = d[b];
        n_en[b]++;
        since[b]++;
      end
      if (clr) since[b] = 0;
    end
  endtask

  function automatic logic [W-1:0] m_data();
    logic [W-1:0] r;
    for (int b = 0; b < W; b++)
      r[b] = (n_en[b] >= D) ? hist[b][n_en[b]-D] : RV[b];
    return r;
  endfunction

  function automatic logic [W-1:0] m_v();
    logic [W-1:0] r;
    for (int b = 0; b < W; b++) r[b] = (since[b] >= D);
    return r;
  endfunction

  function automatic logic [W*CW-1:0] m_cnt();
    logic [W*CW-1:0] r;
    for (int b = 0; b < W; b++) r[b*CW +: CW] = CW'((since[b] > D) ? D : since[b]);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".data_o"}, 32'(data_o), 32'(m_data()));
    check({tag, ".v_o"}, 32'(v_o), 32'(m_v()));
    check({tag, ".count_o"}, 32'(count_o), 32'(m_cnt()));
  endtask

  // Drive one set of inputs across a rising edge; outputs sampled 1 time unit later.
  task automatic step(input logic [W-1:0] en, input logic [W-1:0] d, input logic clr);
    en_i    = en;
    data_i  = d;
    clear_i = clr;
    @(posedge clk_i);
    model_edge(en, d, clr);
    #1;
  endtask

  // Asynchronous reset asserted between edges; outputs must already be at reset values.
  task automatic do_reset(input string tag);
    en_i    = '0;
    clear_i = 1'b0;
    #2;
    reset_i = 1'b1;
    #1;
    check({tag, ".rst_data_o"}, 32'(data_o), 32'(RV));
    check({tag, ".rst_v_o"}, 32'(v_o), 32'h0);
    check({tag, ".rst_count_o"}, 32'(count_o), 32'h0);
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic         rst;
    logic [W-1:0] en;
    logic [W-1:0] data;
    logic         clr;
    logic [W-1:0] exp_data;
    logic [W-1:0] exp_v;
    logic [31:0]  exp_cnt;
  } vec_t;

  vec_t tbl [6];

  initial begin
    reset_i = 1'b0;
    en_i    = '0;
    data_i  = '0;
    clear_i = 1'b0;

    tbl[0] = '{1'b1, 16'hFFFF, 16'h1234, 1'b0, 16'hA5A5, 16'h0000, 32'h5555_5555};
    tbl[1] = '{1'b0, 16'hFFFF, 16'h5678, 1'b0, 16'h1234, 16'hFFFF, 32'hAAAA_AAAA};
    tbl[2] = '{1'b0, 16'hFFFF, 16'h9ABC, 1'b0, 16'h5678, 16'hFFFF, 32'hAAAA_AAAA};
    tbl[3] = '{1'b1, 16'h0001, 16'h0001, 1'b0, 16'hA5A5, 16'h0000, 32'h0000_0001};
    tbl[4] = '{1'b0, 16'h0001, 16'hFFFE, 1'b0, 16'hA5A5, 16'h0001, 32'h0000_0002};
    tbl[5] = '{1'b0, 16'h0001, 16'hFFFF, 1'b0, 16'hA5A4, 16'h0001, 32'h0000_0002};

    do_reset("init");

    // Full-rate fill and single-lane independence.
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].rst) do_reset($sformatf("tbl%0d", i));
      step(tbl[i].en, tbl[i].data, tbl[i].clr);
      check($sformatf("tbl%0d.data_o", i), 32'(data_o), 32'(tbl[i].exp_data));
      check($sformatf("tbl%0d.v_o", i), 32'(v_o), 32'(tbl[i].exp_v));
      check($sformatf("tbl%0d.count_o", i), 32'(count_o), tbl[i].exp_cnt);
    end

    // Gapped enable on lane 3: edges 1, 4, 7 carry bits 1, 0, 1.
    do_reset("gap");
    for (int e = 1; e <= 7; e++) begin
      logic [W-1:0] d;
      d = W'($urandom);
      if (e == 1 || e == 7) d[3] = 1'b1;
      if (e == 4) d[3] = 1'b0;
      step((e == 1 || e == 4 || e == 7) ? 16'h0008 : 16'h0000, d, 1'b0);
      check_model($sformatf("gap%0d", e));
      if (e == 4) begin
        check("gap4.lane3_data", 32'(data_o[3]), 32'h1);
        check("gap4.lane3_v", 32'(v_o[3]), 32'h1);
      end
      if (e == 6) check("gap6.lane3_hold", 32'(data_o[3]), 32'h1);
      if (e == 7) check("gap7.lane3_data", 32'(data_o[3]), 32'h0);
    end

    // Clear has priority over the increment while data keeps shifting.
    step(16'hFFFF, 16'h0F0F, 1'b0);
    step(16'hFFFF, 16'h3C3C, 1'b0);
    step(16'hFFFF, 16'hFFFF, 1'b1);
    check("clr.v_o", 32'(v_o), 32'h0);
    check("clr.count_o", 32'(count_o), 32'h0);
    check("clr.data_o", 32'(data_o), 32'h3C3C);
    step(16'hFFFF, 16'h0000, 1'b0);
    check("clr1.count_o", 32'(count_o), 32'h5555_5555);
    check("clr1.v_o", 32'(v_o), 32'h0);
    check("clr1.data_o", 32'(data_o), 32'hFFFF);
    step(16'hFFFF, 16'h0000, 1'b0);
    check("clr2.v_o", 32'(v_o), 32'hFFFF);

    // Async reset with lanes full, then one enabled edge.
    do_reset("mid");
    step(16'hFFFF, 16'h00FF, 1'b0);
    check("mid1.count_o", 32'(count_o), 32'h5555_5555);
    check("mid1.v_o", 32'(v_o), 32'h0);
    check("mid1.data_o", 32'(data_o), 32'(RV));

    // Randomized run against the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(63) == 0) do_reset($sformatf("rnd%0d", i));
      step(W'($urandom), W'($urandom), ($urandom_range(15) == 0));
      check_model($sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
